// File: rtl/io_handshake_unit_pkg.sv
// Shared definitions for the operator I/O handshake unit: FSM state
// encodings, the default debounce length and small state-decode helpers.
package io_handshake_unit_pkg;

    localparam int DEBOUNCE_DEFAULT = 50000;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_PRESS   = 3'd1,
        ST_DEBOUNCE     = 3'd2,
        ST_WAIT_RELEASE = 3'd3,
        ST_COMMIT       = 3'd4,
        ST_HALTED       = 3'd5
    } state_t;

    // True while the unit is waiting on the operator (press or release).
    function automatic logic is_waiting(input state_t s);
        return (s == ST_WAIT_PRESS) || (s == ST_DEBOUNCE) || (s == ST_WAIT_RELEASE);
    endfunction

    // True while the debounce counter is allowed to run.
    function automatic logic is_counting(input state_t s);
        return (s == ST_WAIT_PRESS) || (s == ST_DEBOUNCE);
    endfunction

endpackage

// File: rtl/io_handshake_unit_if.sv
// Bundle of the decoder strobes, operator inputs and display/writeback
// outputs exchanged between the CPU core and the I/O handshake unit.
interface io_handshake_unit_if #(
    parameter int DATA_W = 32,
    parameter int SW_W   = 16
);
    logic              input_flag;
    logic              output_flag;
    logic              halt;
    logic [SW_W-1:0]   switches;
    logic              confirm_btn;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] in_data;
    logic              stall;
    logic [DATA_W-1:0] display_value;
    logic              display_valid;
    logic              waiting_led;
    logic              halted_led;

    // CPU / board side: drives strobes and operator inputs.
    modport master (
        output input_flag, output_flag, halt, switches, confirm_btn, out_data,
        input  in_data, stall, display_value, display_valid, waiting_led, halted_led
    );

    // Handshake unit side.
    modport slave (
        input  input_flag, output_flag, halt, switches, confirm_btn, out_data,
        output in_data, stall, display_value, display_valid, waiting_led, halted_led
    );
endinterface

// File: rtl/io_handshake_unit_btn_debouncer.sv
// Confirm-button debouncer. Counts consecutive high samples of the raw
// button while the FSM enables it; pressed_stable_o fires on the sample that
// completes DEBOUNCE_CYCLES highs. released_o reports the button being low.
// The counter saturates and never wraps; any low sample or disable clears it.
module io_handshake_unit_btn_debouncer
    import io_handshake_unit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic reset,            // synchronous, active-low
    input  logic count_en_i,
    input  logic btn_i,
    output logic pressed_stable_o,
    output logic released_o
);
    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: advance on each high sample while enabled, saturating at the limit.
    always_comb begin
        count_d = '0;
        if (count_en_i && btn_i) begin
            if (count_q != CNT_MAX) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = count_q;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pressed_stable_o = count_en_i && btn_i && (count_d == CNT_MAX);
    assign released_o       = !btn_i;

endmodule

// File: rtl/io_handshake_unit.sv
// Operator I/O handshake unit. Services the input / output / halt strobes
// from the decoder: input stalls the CPU until a debounced confirm press and
// release, then hands the switch value to writeback for one commit cycle;
// output latches a register onto the display; halt freezes until reset.
// Optional feature macro: OUTPUT_ACK_EN -- when defined, an output also
// waits for an operator press+release before the CPU may continue, and the
// switch value is not captured for that handshake.
module io_handshake_unit
    import io_handshake_unit_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,   // synchronous, active-low
    io_handshake_unit_if.slave bus
);
    state_t            state_q,   state_d;
    logic [DATA_W-1:0] in_data_q, in_data_d;
    logic [DATA_W-1:0] disp_q,    disp_d;
    logic              valid_q,   valid_d;
`ifdef OUTPUT_ACK_EN
    logic              ack_q,     ack_d;
`endif

    logic pressed_stable;
    logic released;
    logic idle_request;

    io_handshake_unit_btn_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock            (clock),
        .reset            (reset),
        .count_en_i       (is_counting(state_q)),
        .btn_i            (bus.confirm_btn),
        .pressed_stable_o (pressed_stable),
        .released_o       (released)
    );

    // Next-state and datapath-update logic for the handshake FSM.
    always_comb begin
        state_d   = state_q;
        in_data_d = in_data_q;
        disp_d    = disp_q;
        valid_d   = valid_q;
`ifdef OUTPUT_ACK_EN
        ack_d     = ack_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.halt) begin
                    state_d = ST_HALTED;
                end else if (bus.input_flag) begin
                    state_d = ST_WAIT_PRESS;
                end else if (bus.output_flag) begin
                    disp_d  = bus.out_data;
                    valid_d = 1'b1;
`ifdef OUTPUT_ACK_EN
                    ack_d   = 1'b1;
                    state_d = ST_WAIT_PRESS;
`endif
                end
            end
            ST_WAIT_PRESS: begin
                if (bus.confirm_btn) begin
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (pressed_stable) begin
`ifdef OUTPUT_ACK_EN
                    if (!ack_q) begin
                        in_data_d = DATA_W'(bus.switches);
                    end
`else
                    in_data_d = DATA_W'(bus.switches);
`endif
                    state_d = ST_WAIT_RELEASE;
                end else if (!bus.confirm_btn) begin
                    // Glitch shorter than the debounce window: start over.
                    state_d = ST_WAIT_PRESS;
                end
            end
            ST_WAIT_RELEASE: begin
                if (released) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // The CPU writes back and advances during this single cycle.
                state_d = ST_IDLE;
`ifdef OUTPUT_ACK_EN
                ack_d   = 1'b0;
`endif
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            in_data_q <= '0;
            disp_q    <= '0;
            valid_q   <= 1'b0;
`ifdef OUTPUT_ACK_EN
            ack_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            in_data_q <= in_data_d;
            disp_q    <= disp_d;
            valid_q   <= valid_d;
`ifdef OUTPUT_ACK_EN
            ack_q     <= ack_d;
`endif
        end
    end

    // A blocking request seen in IDLE stalls its own decode cycle, so the
    // CPU never advances past the instruction before the FSM takes over.
`ifdef OUTPUT_ACK_EN
    assign idle_request = bus.halt || bus.input_flag || bus.output_flag;
`else
    assign idle_request = bus.halt || bus.input_flag;
`endif

    assign bus.stall         = is_waiting(state_q) || (state_q == ST_HALTED) ||
                               ((state_q == ST_IDLE) && idle_request);
    assign bus.in_data       = in_data_q;
    assign bus.display_value = disp_q;
    assign bus.display_valid = valid_q;
    assign bus.waiting_led   = is_waiting(state_q);
    assign bus.halted_led    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_io_handshake_unit.sv
// Bench for the operator I/O handshake unit with a 4-cycle debounce window.
// A transaction-level model tracks whether the unit is halted, waiting on the
// operator, or in its commit cycle, and is compared every cycle against the
// DUT; directed scenarios add hand-computed literal expectations.
module tb_io_handshake_unit;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_handshake_unit_if #(.DATA_W(32), .SW_W(16)) bus ();

    io_handshake_unit #(
        .DATA_W          (32),
        .SW_W            (16),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

`ifdef OUTPUT_ACK_EN
    localparam bit ACK_MODE = 1'b1;
`else
    localparam bit ACK_MODE = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_halt, m_wait, m_got, m_commit, m_ack, m_valid;
    int          m_run;
    logic [31:0] m_in, m_disp;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_halt <= 0; m_wait <= 0; m_got <= 0; m_commit <= 0; m_ack <= 0;
            m_run <= 0; m_in <= 0; m_disp <= 0; m_valid <= 0;
        end else if (m_halt) begin
            m_halt <= 1;
        end else if (m_commit) begin
            m_commit <= 0;
            m_ack    <= 0;
        end else if (m_wait) begin
            if (!m_got) begin
                if (bus.confirm_btn) begin
                    if (m_run + 1 == N) begin
                        if (!m_ack) m_in <= {16'h0, bus.switches};
                        m_got <= 1;
                        m_run <= 0;
                    end else begin
                        m_run <= m_run + 1;
                    end
                end else begin
                    m_run <= 0;
                end
            end else if (!bus.confirm_btn) begin
                m_wait <= 0; m_got <= 0; m_commit <= 1;
            end
        end else begin
            if (bus.halt) m_halt <= 1;
            else if (bus.input_flag) m_wait <= 1;
            else if (bus.output_flag) begin
                m_disp  <= bus.out_data;
                m_valid <= 1;
                if (ACK_MODE) begin
                    m_wait <= 1;
                    m_ack  <= 1;
                end
            end
        end
    end

    function automatic logic model_stall();
        logic idle;
        idle = !(m_halt || m_wait || m_commit);
        return m_halt || m_wait ||
               (idle && (bus.halt || bus.input_flag || (ACK_MODE && bus.output_flag)));
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_stall",   {31'b0, bus.stall},         {31'b0, model_stall()});
            check("model_waiting", {31'b0, bus.waiting_led},   {31'b0, m_wait});
            check("model_halted",  {31'b0, bus.halted_led},    {31'b0, m_halt});
            check("model_in_data", bus.in_data,                m_in);
            check("model_display", bus.display_value,          m_disp);
            check("model_valid",   {31'b0, bus.display_valid}, {31'b0, m_valid});
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full press: N high samples, then release; leaves the unit in COMMIT.
    task automatic press_release();
        bus.confirm_btn = 1'b1;
        step(N);
        bus.confirm_btn = 1'b0;
        step(1);
    endtask

    initial begin
        bus.input_flag  = 0;
        bus.output_flag = 0;
        bus.halt        = 0;
        bus.switches    = 0;
        bus.confirm_btn = 0;
        bus.out_data    = 0;
        step(2);
        chk_en = 1'b1;
        check("reset_stall",   {31'b0, bus.stall}, 32'd0);
        check("reset_in_data", bus.in_data, 32'd0);
        check("reset_valid",   {31'b0, bus.display_valid}, 32'd0);
        rst_n = 1'b1;

        // 1: simple input of 0x00A5
        bus.input_flag = 1; bus.switches = 16'h00A5;
        #1;
        check("t1_first_cycle_stall", {31'b0, bus.stall}, 32'd1);
        step(1);
        bus.confirm_btn = 1; step(N);
        check("t1_in_data", bus.in_data, 32'h0000_00A5);
        check("t1_wait_release_led", {31'b0, bus.waiting_led}, 32'd1);
        bus.confirm_btn = 0; step(1);
        check("t1_commit_stall", {31'b0, bus.stall}, 32'd0);
        bus.input_flag = 0; step(1);
        check("t1_idle_led", {31'b0, bus.waiting_led}, 32'd0);
        $display("txn1 input 00A5 -> in_data=%h", bus.in_data);

        // 2: 2-cycle glitch rejected, then a full press captures 0x1234
        bus.input_flag = 1; bus.switches = 16'h1234;
        step(1);
        bus.confirm_btn = 1; step(2);
        bus.confirm_btn = 0; step(1);
        check("t2_glitch_still_waiting", {31'b0, bus.waiting_led}, 32'd1);
        bus.confirm_btn = 1; step(N - 1);
        check("t2_not_yet_captured", bus.in_data, 32'h0000_00A5);
        step(1);
        check("t2_captured", bus.in_data, 32'h0000_1234);
        bus.confirm_btn = 0; step(1);
        check("t2_commit_stall", {31'b0, bus.stall}, 32'd0);
        bus.input_flag = 0; step(1);
        $display("txn2 glitch+input 1234 -> in_data=%h", bus.in_data);

        // 3: output of 0xDEADBEEF (6: with the ack option it also waits for the operator)
        bus.output_flag = 1; bus.out_data = 32'hDEAD_BEEF;
        #1;
        check("t3_output_stall", {31'b0, bus.stall}, {31'b0, ACK_MODE});
        step(1);
        check("t3_display", bus.display_value, 32'hDEAD_BEEF);
        check("t3_valid", {31'b0, bus.display_valid}, 32'd1);
`ifdef OUTPUT_ACK_EN
        check("t6_ack_stall", {31'b0, bus.stall}, 32'd1);
        bus.switches = 16'h7777;
        press_release();
        check("t6_commit_stall", {31'b0, bus.stall}, 32'd0);
        check("t6_in_data_kept", bus.in_data, 32'h0000_1234);
`else
        check("t3_no_stall", {31'b0, bus.stall}, 32'd0);
`endif
        bus.output_flag = 0; step(1);
        $display("txn3 output DEADBEEF -> display=%h valid=%0d", bus.display_value, bus.display_valid);

        // 7: back-to-back inputs; second starts a fresh handshake after COMMIT
        bus.input_flag = 1; bus.switches = 16'h0042;
        step(1);
        press_release();
        check("t7_commit1", bus.in_data, 32'h0000_0042);
        bus.switches = 16'h0043;
        step(1);
        check("t7_fresh_stall", {31'b0, bus.stall}, 32'd1);
        step(1);
        press_release();
        check("t7_commit2", bus.in_data, 32'h0000_0043);
        bus.input_flag = 0; step(1);
        $display("txn7 back-to-back input -> in_data=%h", bus.in_data);

        // 4: halt beats input_flag; button ignored; reset recovers
        bus.halt = 1; bus.input_flag = 1;
        step(1);
        check("t4_halted_led", {31'b0, bus.halted_led}, 32'd1);
        check("t4_halt_stall", {31'b0, bus.stall}, 32'd1);
        bus.switches = 16'hFFFF;
        bus.confirm_btn = 1; step(N + 2);
        bus.confirm_btn = 0; step(2);
        check("t4_still_halted", {31'b0, bus.halted_led}, 32'd1);
        check("t4_in_data_kept", bus.in_data, 32'h0000_0043);
        rst_n = 0; bus.halt = 0; bus.input_flag = 0;
        step(1);
        rst_n = 1;
        check("t4_reset_halted", {31'b0, bus.halted_led}, 32'd0);
        check("t4_reset_in_data", bus.in_data, 32'd0);
        check("t4_reset_display", bus.display_value, 32'd0);
        check("t4_reset_valid", {31'b0, bus.display_valid}, 32'd0);
        $display("txn4 halt+reset -> halted=%0d stall=%0d", bus.halted_led, bus.stall);

        // 5: reset during debounce aborts the input
        bus.input_flag = 1; bus.switches = 16'h00FF;
        step(1);
        bus.confirm_btn = 1; step(2);
        check("t5_in_debounce", {31'b0, bus.waiting_led}, 32'd1);
        rst_n = 0; bus.input_flag = 0; bus.confirm_btn = 0;
        step(1);
        rst_n = 1;
        check("t5_abort_led", {31'b0, bus.waiting_led}, 32'd0);
        check("t5_abort_in_data", bus.in_data, 32'd0);
        step(3);
        check("t5_no_commit", bus.in_data, 32'd0);
        check("t5_idle_stall", {31'b0, bus.stall}, 32'd0);
        $display("txn5 reset mid-debounce -> in_data=%h", bus.in_data);

        chk_en = 1'b0;
        step(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
